// File: rtl/nubus_master_seq.sv
// NuBus master sequencer: arbitrates for the bus, runs one address cycle and one
// data phase per CPU request, and handles slave retries, errors and local timeout.
module nubus_master_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RETRY_GAP      = 2
) (
  input  logic        nub_clkn,
  input  logic        nub_reset,
  input  logic        cpu_valid,
  input  logic        cpu_masterd,
  input  logic        cpu_error,
  input  logic        cpu_write,
  input  logic        nub_grant,
  input  logic        nub_busy,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_ad_i,
  output logic        nub_rqstn_o,
  output logic        nub_startn_o,
  output logic        mst_adrcyn_o,
  output logic        mst_dtacyn_o,
  output logic        cpu_ready_o,
  output logic [1:0]  cpu_status_o,
  output logic [31:0] cpu_rdata_o
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GapW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES);
  localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);
  localparam logic [GapW-1:0] GapLast = GapW'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StAddr,
    StData,
    StRetryWait,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [RtyW-1:0] rty_q, rty_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [1:0]      status_q, status_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            wr_q, wr_d;

  logic [1:0]      ack_st;
  logic [TmoW-1:0] tmo_inc;

  assign ack_st  = {~nub_tm1n, ~nub_tm0n};
  assign tmo_inc = tmo_q + TmoW'(1);

  // State and datapath registers; reset aborts any transaction silently.
  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      rty_q    <= '0;
      gap_q    <= '0;
      status_q <= 2'b00;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      rty_q    <= rty_d;
      gap_q    <= gap_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
    end
  end

  // Next-state, counters and completion status.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    rty_d    = rty_q;
    gap_d    = gap_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    wr_d     = wr_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_valid && cpu_masterd) begin
          wr_d = cpu_write;
          if (cpu_error) begin
            status_d = 2'b01;
            state_d  = StDone;
          end else begin
            state_d = StArb;
          end
        end
      end
      StArb: begin
        if (nub_grant && !nub_busy) state_d = StAddr;
      end
      StAddr: begin
        tmo_d   = '0;
        state_d = StData;
      end
      StData: begin
        // An ack on the terminal-count cycle wins over the timeout.
        if (!nub_ackn) begin
          unique case (ack_st)
            2'b00: begin
              status_d = 2'b00;
              if (!wr_q) rdata_d = nub_ad_i;
              state_d = StDone;
            end
            2'b01: begin
              status_d = 2'b01;
              state_d  = StDone;
            end
            2'b10: begin
              status_d = 2'b10;
              state_d  = StDone;
            end
            default: begin
              if (rty_q < RtyMax) begin
                rty_d   = rty_q + RtyW'(1);
                gap_d   = '0;
                state_d = (RETRY_GAP == 0) ? StArb : StRetryWait;
              end else begin
                status_d = 2'b11;
                state_d  = StDone;
              end
            end
          endcase
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TmoLast) begin
            status_d = 2'b10;
            state_d  = StDone;
          end
        end
      end
      StRetryWait: begin
        if (gap_q == GapLast) state_d = StArb;
        else gap_d = gap_q + GapW'(1);
      end
      StDone: begin
        rty_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus strobes decoded from the current state; idle values everywhere else.
  always_comb begin
    nub_rqstn_o  = 1'b1;
    nub_startn_o = 1'b1;
    mst_adrcyn_o = 1'b1;
    mst_dtacyn_o = 1'b1;
    cpu_ready_o  = 1'b0;
    unique case (state_q)
      StArb:  nub_rqstn_o = 1'b0;
      StAddr: begin
        nub_startn_o = 1'b0;
        mst_adrcyn_o = 1'b0;
      end
      StData: mst_dtacyn_o = 1'b0;
      StDone: cpu_ready_o  = 1'b1;
      default: ;
    endcase
  end

  assign cpu_status_o = status_q;
  assign cpu_rdata_o  = rdata_q;

endmodule

// File: tb/tb_nubus_master_seq.sv
// Directed bench for nubus_master_seq: a per-cycle vector table plus hand-written
// sequences for retry, timeout, long busy and mid-transaction reset.
module tb_nubus_master_seq;

  logic        nub_clkn = 1'b0;
  logic        nub_reset;
  logic        cpu_valid, cpu_masterd, cpu_error, cpu_write;
  logic        nub_grant, nub_busy, nub_ackn, nub_tm1n, nub_tm0n;
  logic [31:0] nub_ad_i;
  logic        nub_rqstn_o, nub_startn_o, mst_adrcyn_o, mst_dtacyn_o, cpu_ready_o;
  logic [1:0]  cpu_status_o;
  logic [31:0] cpu_rdata_o;

  nubus_master_seq dut (
    .nub_clkn    (nub_clkn),
    .nub_reset   (nub_reset),
    .cpu_valid   (cpu_valid),
    .cpu_masterd (cpu_masterd),
    .cpu_error   (cpu_error),
    .cpu_write   (cpu_write),
    .nub_grant   (nub_grant),
    .nub_busy    (nub_busy),
    .nub_ackn    (nub_ackn),
    .nub_tm1n    (nub_tm1n),
    .nub_tm0n    (nub_tm0n),
    .nub_ad_i    (nub_ad_i),
    .nub_rqstn_o (nub_rqstn_o),
    .nub_startn_o(nub_startn_o),
    .mst_adrcyn_o(mst_adrcyn_o),
    .mst_dtacyn_o(mst_dtacyn_o),
    .cpu_ready_o (cpu_ready_o),
    .cpu_status_o(cpu_status_o),
    .cpu_rdata_o (cpu_rdata_o)
  );

  always #5 nub_clkn = ~nub_clkn;

  typedef struct packed {
    logic valid, masterd, error, write, grant, busy, ackn, tm1n, tm0n;
    logic [31:0] ad;
  } in_t;

  typedef struct packed {
    logic rqstn, startn, adrcyn, dtacyn, ready;
    logic [1:0]  status;
    logic [31:0] rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int KI = 0;  // idle, retry-wait and reset look alike on the bus
  localparam int KA = 1;
  localparam int KAD = 2;
  localparam int KDT = 3;
  localparam int KDN = 4;

  int n_checks = 0;
  int n_fail   = 0;
  int startn_cnt = 0;
  int ready_cnt  = 0;

  always @(negedge nub_clkn) begin
    if (!nub_startn_o) startn_cnt++;
    if (cpu_ready_o) ready_cnt++;
  end

  function automatic in_t mk_in(input logic v, m, e, w, g, b, a, t1, t0,
                                input logic [31:0] ad);
    in_t r;
    r = '{valid: v, masterd: m, error: e, write: w, grant: g, busy: b,
          ackn: a, tm1n: t1, tm0n: t0, ad: ad};
    return r;
  endfunction

  function automatic out_t exp_o(input int k, input logic [1:0] s, input logic [31:0] d);
    out_t o;
    o = '{rqstn: 1'b1, startn: 1'b1, adrcyn: 1'b1, dtacyn: 1'b1, ready: 1'b0,
          status: s, rdata: d};
    case (k)
      KA:  o.rqstn = 1'b0;
      KAD: begin o.startn = 1'b0; o.adrcyn = 1'b0; end
      KDT: o.dtacyn = 1'b0;
      KDN: o.ready = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic drive(input in_t i);
    cpu_valid   = i.valid;
    cpu_masterd = i.masterd;
    cpu_error   = i.error;
    cpu_write   = i.write;
    nub_grant   = i.grant;
    nub_busy    = i.busy;
    nub_ackn    = i.ackn;
    nub_tm1n    = i.tm1n;
    nub_tm0n    = i.tm0n;
    nub_ad_i    = i.ad;
  endtask

  task automatic check(input string name, input out_t e);
    out_t act;
    act = {nub_rqstn_o, nub_startn_o, mst_adrcyn_o, mst_dtacyn_o, cpu_ready_o,
           cpu_status_o, cpu_rdata_o};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: {rq,st,adr,dta,rdy,status} got %b rdata %h, expected %b rdata %h",
               name, act[38:32], act.rdata, e[38:32], e.rdata);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check just before the rising edge.
  task automatic cyc(input string name, input in_t i, input out_t e);
    @(negedge nub_clkn);
    drive(i);
    #4;
    check(name, e);
  endtask

  in_t  idle_i;
  vec_t tbl[$];
  int   sc;
  int   rc;

  initial begin
    idle_i = mk_in(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0);
    drive(idle_i);
    nub_reset = 1'b1;
    #1;
    check("reset_values", exp_o(KI, 2'b00, 32'h0));
    #16 nub_reset = 1'b0;

    // Read with late grant, write with st=01, read with st=10, error, ignored
    // non-NuBus request and a back-to-back request held through DONE.
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KI, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KA, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KA, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,1,0,1,1,1,0),            exp_o(KA, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KAD, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KDT, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KDT, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,0,1,1,32'hDEADBEEF), exp_o(KDT, 0, 0)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KDN, 0, 32'hDEADBEEF)});
    tbl.push_back('{idle_i,                                exp_o(KI, 0, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,1,0,0,0,1,1,1,0),            exp_o(KI, 0, 32'hDEADBEEF)});
    tbl.push_back('{idle_i,                                exp_o(KDN, 1, 32'hDEADBEEF)});
    tbl.push_back('{idle_i,                                exp_o(KI, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,0,0,0,1,0,1,1,1,0),            exp_o(KI, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,0,0,0,1,0,1,1,1,0),            exp_o(KI, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,0,1,1,0,1,1,1,0),            exp_o(KI, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(0,0,0,1,1,0,1,1,1,0),            exp_o(KA, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(0,0,0,1,0,0,1,1,1,0),            exp_o(KAD, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(0,0,0,1,0,0,0,1,0,32'h12345678), exp_o(KDT, 1, 32'hDEADBEEF)});
    tbl.push_back('{idle_i,                                exp_o(KDN, 1, 32'hDEADBEEF)});
    tbl.push_back('{idle_i,                                exp_o(KI, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,0,0,1,0,1,1,1,0),            exp_o(KI, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,0,0,1,0,1,1,1,0),            exp_o(KA, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KAD, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,0,0,1,32'hCAFEF00D), exp_o(KDT, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,0,0,0,0,1,1,1,0),            exp_o(KDN, 2, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(1,1,0,0,1,0,1,1,1,0),            exp_o(KI, 2, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(0,0,0,0,1,0,1,1,1,0),            exp_o(KA, 2, 32'hDEADBEEF)});
    tbl.push_back('{idle_i,                                exp_o(KAD, 2, 32'hDEADBEEF)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,0,1,1,32'h0BADF00D), exp_o(KDT, 2, 32'hDEADBEEF)});
    tbl.push_back('{idle_i,                                exp_o(KDN, 0, 32'h0BADF00D)});
    tbl.push_back('{idle_i,                                exp_o(KI, 0, 32'h0BADF00D)});

    for (int v = 0; v < tbl.size(); v++) begin
      cyc($sformatf("vec%0d", v), tbl[v].i, tbl[v].o);
    end

    // Four try-again-later answers: three retries with a two-cycle gap, then status 11.
    sc = startn_cnt;
    cyc("retry_req", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KI, 0, 32'h0BADF00D));
    for (int t = 0; t < 4; t++) begin
      cyc($sformatf("retry%0d_arb", t), mk_in(0,0,0,0,1,0,1,1,1,0),
          exp_o(KA, 0, 32'h0BADF00D));
      cyc($sformatf("retry%0d_addr", t), idle_i, exp_o(KAD, 0, 32'h0BADF00D));
      cyc($sformatf("retry%0d_data", t), mk_in(0,0,0,0,0,0,0,0,0,32'h0),
          exp_o(KDT, 0, 32'h0BADF00D));
      if (t < 3) begin
        cyc($sformatf("retry%0d_gap1", t), mk_in(0,0,0,0,1,0,1,1,1,0),
            exp_o(KI, 0, 32'h0BADF00D));
        cyc($sformatf("retry%0d_gap2", t), mk_in(0,0,0,0,1,0,1,1,1,0),
            exp_o(KI, 0, 32'h0BADF00D));
      end
    end
    cyc("retry_done", idle_i, exp_o(KDN, 3, 32'h0BADF00D));
    cyc("retry_idle", idle_i, exp_o(KI, 3, 32'h0BADF00D));
    check_int("retry_startn_pulses", startn_cnt - sc, 4);

    // No ack: timeout at the 255th data cycle.
    cyc("tmo_req", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KI, 3, 32'h0BADF00D));
    cyc("tmo_arb", mk_in(0,0,0,0,1,0,1,1,1,0), exp_o(KA, 3, 32'h0BADF00D));
    cyc("tmo_addr", idle_i, exp_o(KAD, 3, 32'h0BADF00D));
    for (int k = 1; k <= 255; k++) begin
      cyc($sformatf("tmo_data%0d", k), idle_i, exp_o(KDT, 3, 32'h0BADF00D));
    end
    cyc("tmo_done", idle_i, exp_o(KDN, 2, 32'h0BADF00D));
    cyc("tmo_idle", idle_i, exp_o(KI, 2, 32'h0BADF00D));

    // Ack on the terminal-count cycle wins.
    cyc("tmoack_req", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KI, 2, 32'h0BADF00D));
    cyc("tmoack_arb", mk_in(0,0,0,0,1,0,1,1,1,0), exp_o(KA, 2, 32'h0BADF00D));
    cyc("tmoack_addr", idle_i, exp_o(KAD, 2, 32'h0BADF00D));
    for (int k = 1; k <= 254; k++) begin
      cyc($sformatf("tmoack_data%0d", k), idle_i, exp_o(KDT, 2, 32'h0BADF00D));
    end
    cyc("tmoack_data255", mk_in(0,0,0,0,0,0,0,1,1,32'hA5A55A5A),
        exp_o(KDT, 2, 32'h0BADF00D));
    cyc("tmoack_done", idle_i, exp_o(KDN, 0, 32'hA5A55A5A));
    cyc("tmoack_idle", idle_i, exp_o(KI, 0, 32'hA5A55A5A));

    // Grant while another master holds the bus: stay requesting until busy drops.
    cyc("busy_req", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KI, 0, 32'hA5A55A5A));
    for (int b = 0; b < 10; b++) begin
      cyc($sformatf("busy_arb%0d", b), mk_in(0,0,0,0,1,1,1,1,1,0),
          exp_o(KA, 0, 32'hA5A55A5A));
    end
    cyc("busy_fall", mk_in(0,0,0,0,1,0,1,1,1,0), exp_o(KA, 0, 32'hA5A55A5A));
    cyc("busy_addr", idle_i, exp_o(KAD, 0, 32'hA5A55A5A));
    cyc("busy_data", mk_in(0,0,0,0,0,0,0,1,1,32'h13579BDF), exp_o(KDT, 0, 32'hA5A55A5A));
    cyc("busy_done", idle_i, exp_o(KDN, 0, 32'h13579BDF));
    cyc("busy_idle", idle_i, exp_o(KI, 0, 32'h13579BDF));

    // Reset in the middle of the data phase, then a normal read.
    cyc("rst_req", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KI, 0, 32'h13579BDF));
    cyc("rst_arb", mk_in(1,1,0,0,1,0,1,1,1,0), exp_o(KA, 0, 32'h13579BDF));
    cyc("rst_addr", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KAD, 0, 32'h13579BDF));
    cyc("rst_data", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KDT, 0, 32'h13579BDF));
    rc = ready_cnt;
    #2;
    nub_reset = 1'b1;
    #1;
    check("rst_async", exp_o(KI, 0, 32'h0));
    drive(idle_i);
    #10 nub_reset = 1'b0;
    cyc("rst_after1", idle_i, exp_o(KI, 0, 32'h0));
    cyc("rst_after2", idle_i, exp_o(KI, 0, 32'h0));
    check_int("rst_no_ready", ready_cnt - rc, 0);
    cyc("post_req", mk_in(1,1,0,0,0,0,1,1,1,0), exp_o(KI, 0, 32'h0));
    cyc("post_arb", mk_in(0,0,0,0,1,0,1,1,1,0), exp_o(KA, 0, 32'h0));
    cyc("post_addr", idle_i, exp_o(KAD, 0, 32'h0));
    cyc("post_data", mk_in(0,0,0,0,0,0,0,1,1,32'hFEEDFACE), exp_o(KDT, 0, 32'h0));
    cyc("post_done", idle_i, exp_o(KDN, 0, 32'hFEEDFACE));
    cyc("post_idle", idle_i, exp_o(KI, 0, 32'hFEEDFACE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
